// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command scheduler.
// State encoding, init ROM, default timings, clear/home codes.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWR,
    S_INIT_SETUP,
    S_INIT_EN,
    S_INIT_HOLD,
    S_IDLE,
    S_SETUP,
    S_EN,
    S_HOLD
  } state_t;

  localparam logic [19:0] T_PWR_DEF = 20'hFFFFF;
  localparam logic [19:0] T_EN_DEF  = 20'd16;
  localparam logic [19:0] T_CMD_DEF = 20'h40000;
  localparam logic [19:0] T_CLR_DEF = 20'hFFFFF;

  localparam logic [8:0] W_CLEAR = 9'h001;
  localparam logic [8:0] W_HOME  = 9'h002;

  localparam logic [2:0] INIT_LAST = 3'd7;

  function automatic logic [8:0] init_word(
    input logic [2:0] idx
  );
    logic [8:0] w;
    case (idx)
      3'd0:    w = 9'h030;
      3'd1:    w = 9'h030;
      3'd2:    w = 9'h030;
      3'd3:    w = 9'h038;
      3'd4:    w = 9'h00C;
      3'd5:    w = 9'h001;
      3'd6:    w = 9'h006;
      default: w = 9'h080;
    endcase
    return w;
  endfunction

  // Clear and home need the long settle time.
  function automatic logic is_long(
    input logic [8:0] w
  );
    return (w == W_CLEAR) || (w == W_HOME);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// 20-bit loadable down counter; stops at zero.
// Ports: clk, rst_n, load, load_val in; done out (count == 0).
module lcd_timer #(
  parameter logic [19:0] RST_VAL = 20'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [19:0] load_val,
  output logic        done
);

  logic [19:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 20'd0) begin
      cnt <= cnt - 20'd1;
    end
  end

  assign done = (cnt == 20'd0);

endmodule

// File: rtl/lcd_cmd_sched.sv
// HD44780-style LCD scheduler: power-up init, then 2-way arbitration.
// Ports: CLOCK_50, RESET_N; req0/1 valid/data/lock in, ready out;
// LCD_ON/BLON/EN/RS/RW/DATA pins; init_done, busy status.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter logic [19:0] T_PWR = T_PWR_DEF,
  parameter logic [19:0] T_EN  = T_EN_DEF,
  parameter logic [19:0] T_CMD = T_CMD_DEF,
  parameter logic [19:0] T_CLR = T_CLR_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       req0_valid,
  input  logic [8:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [8:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_DATA,
  output logic       init_done,
  output logic       busy
);

  state_t      state, state_n;
  logic [8:0]  data_q;
  logic [2:0]  init_idx;
  logic        owner_vld;
  logic        owner_id;
  logic        last;

  logic        t_load;
  logic [19:0] t_val;
  logic        t_done;

  logic [1:0]  vld;
  logic [1:0]  lck;
  logic        g_vld;
  logic        g_id;
  logic        clr_owner;
  logic [1:0]  rdy;
  logic        xfer;
  logic [19:0] hold_ld;

  assign vld = {req1_valid, req0_valid};
  assign lck = {req1_lock, req0_lock};

  // Timer is loaded with N-1 so a state lasts exactly N cycles.
  assign hold_ld = is_long(data_q) ? (T_CLR - 20'd1)
                                   : (T_CMD - 20'd1);

  lcd_timer #(
    .RST_VAL (T_PWR - 20'd1)
  ) u_timer (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // Grant: a locking owner excludes the other side; otherwise
  // round-robin against the last served requester.
  always_comb begin
    g_vld     = 1'b0;
    g_id      = 1'b0;
    clr_owner = 1'b0;
    if (owner_vld) begin
      g_vld     = 1'b1;
      g_id      = owner_id;
      clr_owner = (state == S_IDLE) &&
                  !vld[owner_id] && !lck[owner_id];
    end else if (vld[0] && vld[1]) begin
      g_vld = 1'b1;
      g_id  = ~last;
    end else if (vld[0]) begin
      g_vld = 1'b1;
      g_id  = 1'b0;
    end else if (vld[1]) begin
      g_vld = 1'b1;
      g_id  = 1'b1;
    end
  end

  always_comb begin
    rdy = 2'b00;
    if ((state == S_IDLE) && init_done && g_vld) begin
      rdy[0] = !g_id && vld[0];
      rdy[1] =  g_id && vld[1];
    end
  end

  assign xfer       = |rdy;
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_val   = 20'd0;
    unique case (state)
      S_PWR: begin
        if (t_done) begin
          state_n = S_INIT_SETUP;
          t_load  = 1'b1;
        end
      end
      S_INIT_SETUP: begin
        state_n = S_INIT_EN;
        t_load  = 1'b1;
        t_val   = T_EN - 20'd1;
      end
      S_INIT_EN: begin
        if (t_done) begin
          state_n = S_INIT_HOLD;
          t_load  = 1'b1;
          t_val   = hold_ld;
        end
      end
      S_INIT_HOLD: begin
        if (t_done) begin
          t_load  = 1'b1;
          state_n = (init_idx == INIT_LAST) ? S_IDLE
                                            : S_INIT_SETUP;
        end
      end
      S_IDLE: begin
        if (xfer) begin
          state_n = S_SETUP;
          t_load  = 1'b1;
        end
      end
      S_SETUP: begin
        state_n = S_EN;
        t_load  = 1'b1;
        t_val   = T_EN - 20'd1;
      end
      S_EN: begin
        if (t_done) begin
          state_n = S_HOLD;
          t_load  = 1'b1;
          t_val   = hold_ld;
        end
      end
      S_HOLD: begin
        if (t_done) begin
          state_n = S_IDLE;
          t_load  = 1'b1;
        end
      end
      default: begin
        state_n = S_PWR;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_PWR;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q    <= 9'h000;
      init_idx  <= 3'd0;
      init_done <= 1'b0;
      owner_vld <= 1'b0;
      owner_id  <= 1'b0;
      last      <= 1'b1;
    end else begin
      if ((state == S_PWR) && t_done) begin
        init_idx <= 3'd0;
        data_q   <= init_word(3'd0);
      end
      if ((state == S_INIT_HOLD) && t_done) begin
        if (init_idx == INIT_LAST) begin
          init_done <= 1'b1;
        end else begin
          init_idx <= init_idx + 3'd1;
          data_q   <= init_word(init_idx + 3'd1);
        end
      end
      if (xfer) begin
        data_q    <= rdy[1] ? req1_data : req0_data;
        last      <= rdy[1];
        owner_vld <= rdy[1] ? req1_lock : req0_lock;
        owner_id  <= rdy[1];
      end else if (clr_owner) begin
        owner_vld <= 1'b0;
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign LCD_EN   = (state == S_EN) || (state == S_INIT_EN);
  assign LCD_RS   = data_q[8];
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b0;
  // Write-only panel: RW is tied low, so the bus is always driven.
  assign LCD_DATA = data_q[7:0];

endmodule
